// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the RV32 pipeline blocks:
//     - instruction op-class codes as produced by decode
//     - ALU opcode values, encoded as {funct7[5], funct7[0], funct3}
//     - forwarding-select enum used by the EX operand forwarding unit
//     - alu_op_map(): decode fields -> 5-bit ALU opcode
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [1:0] OPC_R  = 2'b00;  // register-register arithmetic
    localparam logic [1:0] OPC_I  = 2'b01;  // register-immediate arithmetic
    localparam logic [1:0] OPC_LS = 2'b10;  // load / store (address add)
    localparam logic [1:0] OPC_BR = 2'b11;  // conditional branch (compare via subtract)

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b10000;
    localparam logic [4:0] ALU_MUL = 5'b01000;
    localparam logic [4:0] ALU_AND = 5'b00111;
    localparam logic [4:0] ALU_OR  = 5'b00110;
    localparam logic [4:0] ALU_SLL = 5'b00001;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // For I-type arithmetic the funct7 positions hold immediate bits, so they
    // are dropped; otherwise ADDI with a negative immediate would decode as SUB.
    function automatic logic [4:0] alu_op_map(
        input logic [1:0] op_class,
        input logic       funct7_5,
        input logic       funct7_0,
        input logic [2:0] funct3
    );
        logic [4:0] op;
        case (op_class)
            OPC_R:   op = {funct7_5, funct7_0, funct3};
            OPC_I:   op = {2'b00, funct3};
            OPC_LS:  op = ALU_ADD;
            default: op = ALU_SUB;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_forward_unit.sv
// -----------------------------------------------------------------------------
// ex_forward_unit
//   Combinational operand forwarding for one EX source operand.
//   Ports:
//     rs              : source register index held in the ID/EX register
//     reg_data        : operand value captured in the ID/EX register
//     exmem_rd/_regwrite/_result : producer currently in EX/MEM
//     memwb_rd/_regwrite/_result : producer currently in MEM/WB
//     fwd_data        : operand value to use in EX
//   EX/MEM is the younger producer and wins over MEM/WB; x0 is never forwarded.
// -----------------------------------------------------------------------------
module ex_forward_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_regwrite,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_regwrite,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] fwd_data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        case (sel)
            FWD_EXMEM: fwd_data = exmem_result;
            FWD_MEMWB: fwd_data = memwb_result;
            default:   fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the five-stage RV32 core. Captures decoded
//   operands/control, resolves RAW hazards (forwarding or stalling), drives the
//   ALU operands/opcode and passes memory/writeback control to EX/MEM.
//
//   Build option: ID_EX_FORWARD_EN
//     defined     : EX/MEM and MEM/WB forwarding muxes; stall only on load-use.
//     not defined : no forwarding muxes; stall on any RAW against the EX stage
//                   or EX/MEM. The MEM/WB capture-time bypass is kept in both.
//
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     id_*                          : decoded instruction from ID
//     exmem_*, memwb_*              : downstream producers for forwarding
//     stall_in                      : downstream freeze (hold all state)
//     flush                         : taken branch, squash this stage
//     hazard_stall                  : hold PC and IF/ID, decode not accepted
//     alu_a, alu_b, alu_op          : ALU inputs
//     ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_store_data
//                                   : to the EX/MEM register
// -----------------------------------------------------------------------------
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic            id_funct7_0,
    input  logic [1:0]      id_op_class,
    input  logic            id_alu_src,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_regwrite,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_regwrite,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            stall_in,
    input  logic            flush,
    output logic            hazard_stall,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_op,
    output logic            ex_valid,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_store_data
);

    // ID/EX register state
    logic            valid_q,    valid_d;
    logic [4:0]      rs1_q,      rs1_d;
    logic [4:0]      rs2_q,      rs2_d;
    logic [4:0]      rd_q,       rd_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic            alu_src_q,  alu_src_d;
    logic [4:0]      alu_op_q,   alu_op_d;
    logic            regwrite_q, regwrite_d;
    logic            memread_q,  memread_d;
    logic            memwrite_q, memwrite_d;

    // Capture-time bypass: the register file is written by WB in the same
    // cycle it is read by ID, so take the WB value directly.
    logic [XLEN-1:0] cap_rs1_data;
    logic [XLEN-1:0] cap_rs2_data;

    always_comb begin
        cap_rs1_data = id_rs1_data;
        cap_rs2_data = id_rs2_data;
        if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == id_rs1)) begin
            cap_rs1_data = memwb_result;
        end
        if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == id_rs2)) begin
            cap_rs2_data = memwb_result;
        end
    end

    // Hazard detection against the instruction currently held in EX
    logic ex_rd_match;
    assign ex_rd_match = (rd_q != 5'd0) && ((rd_q == id_rs1) || (rd_q == id_rs2));

`ifdef ID_EX_FORWARD_EN
    // Only a load in EX cannot be forwarded in time: one bubble, then its
    // data arrives through MEM/WB forwarding.
    assign hazard_stall = valid_q & memread_q & ex_rd_match & id_valid;
`else
    // Without forwarding, wait until the producer reaches MEM/WB, where the
    // capture-time bypass picks its result up.
    logic raw_ex;
    logic raw_exmem;
    assign raw_ex    = valid_q & regwrite_q & ex_rd_match;
    assign raw_exmem = exmem_regwrite && (exmem_rd != 5'd0)
                       && ((exmem_rd == id_rs1) || (exmem_rd == id_rs2));
    assign hazard_stall = id_valid & (raw_ex | raw_exmem);
`endif

    // Next-state: flush > stall_in > hazard bubble > capture.
    // Flush and bubble only drop valid; the held payload is inert because all
    // side-effecting controls are gated by valid.
    always_comb begin
        valid_d    = valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        alu_src_d  = alu_src_q;
        alu_op_d   = alu_op_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall_in) begin
            valid_d = valid_q;
        end else if (hazard_stall) begin
            valid_d = 1'b0;
        end else begin
            valid_d    = id_valid;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            rs1_data_d = cap_rs1_data;
            rs2_data_d = cap_rs2_data;
            imm_d      = id_imm;
            alu_src_d  = id_alu_src;
            alu_op_d   = alu_op_map(id_op_class, id_funct7_5, id_funct7_0, id_funct3);
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            alu_src_q  <= 1'b0;
            alu_op_q   <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            alu_src_q  <= alu_src_d;
            alu_op_q   <= alu_op_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
        end
    end

    // Operand paths: index 0 = rs1, index 1 = rs2
    logic [4:0]      op_rs   [2];
    logic [XLEN-1:0] op_data [2];
    logic [XLEN-1:0] op_fwd  [2];

    assign op_rs[0]   = rs1_q;
    assign op_rs[1]   = rs2_q;
    assign op_data[0] = rs1_data_q;
    assign op_data[1] = rs2_data_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
`ifdef ID_EX_FORWARD_EN
            ex_forward_unit #(
                .XLEN(XLEN)
            ) u_fwd (
                .rs             (op_rs[gi]),
                .reg_data       (op_data[gi]),
                .exmem_rd       (exmem_rd),
                .exmem_regwrite (exmem_regwrite),
                .exmem_result   (exmem_result),
                .memwb_rd       (memwb_rd),
                .memwb_regwrite (memwb_regwrite),
                .memwb_result   (memwb_result),
                .fwd_data       (op_fwd[gi])
            );
`else
            assign op_fwd[gi] = op_data[gi];
`endif
        end
    endgenerate

`ifndef ID_EX_FORWARD_EN
    // Source indices and the EX/MEM result only feed the forwarding muxes.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exmem_result, op_rs[0], op_rs[1]};
`endif

    assign alu_a         = op_fwd[0];
    assign alu_b         = alu_src_q ? imm_q : op_fwd[1];
    assign ex_store_data = op_fwd[1];
    assign alu_op        = alu_op_q;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = valid_q & regwrite_q;
    assign ex_memread    = valid_q & memread_q;
    assign ex_memwrite   = valid_q & memwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed test of id_ex_stage. Inputs change on the falling edge, outputs
//   are checked on the falling edge (or 1 ns after it for combinational paths).
//   Expected values for forwarding-dependent results follow ID_EX_FORWARD_EN.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int XLEN = 32;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [2:0]      id_funct3;
    logic            id_funct7_5, id_funct7_0;
    logic [1:0]      id_op_class;
    logic            id_alu_src, id_regwrite, id_memread, id_memwrite;
    logic [4:0]      exmem_rd, memwb_rd;
    logic            exmem_regwrite, memwb_regwrite;
    logic [XLEN-1:0] exmem_result, memwb_result;
    logic            stall_in, flush;
    logic            hazard_stall;
    logic [XLEN-1:0] alu_a, alu_b, ex_store_data;
    logic [4:0]      alu_op, ex_rd;
    logic            ex_valid, ex_regwrite, ex_memread, ex_memwrite;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_funct3      (id_funct3),
        .id_funct7_5    (id_funct7_5),
        .id_funct7_0    (id_funct7_0),
        .id_op_class    (id_op_class),
        .id_alu_src     (id_alu_src),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .id_memwrite    (id_memwrite),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_result   (memwb_result),
        .stall_in       (stall_in),
        .flush          (flush),
        .hazard_stall   (hazard_stall),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op         (alu_op),
        .ex_valid       (ex_valid),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_rd          (ex_rd),
        .ex_store_data  (ex_store_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic [1:0] cls, input logic f75, input logic f70,
                          input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src, input logic rw,
                          input logic mr, input logic mw);
        id_valid    = 1'b1;
        id_op_class = cls;
        id_funct7_5 = f75;
        id_funct7_0 = f70;
        id_funct3   = f3;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = imm;
        id_alu_src  = src;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = mw;
    endtask

    task automatic fwd_in(input logic [4:0] erd, input logic erw, input logic [31:0] eres,
                          input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
        exmem_rd       = erd;
        exmem_regwrite = erw;
        exmem_result   = eres;
        memwb_rd       = wrd;
        memwb_regwrite = wrw;
        memwb_result   = wres;
    endtask

    initial begin
        rst = 1'b1;
        stall_in = 1'b0;
        flush = 1'b0;
        fwd_in(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        set_id(OPC_R, 1'b0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset with a valid decode instruction present
        tick();
        tick();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_regwrite", ex_regwrite, 0);
        check("rst_hazard", hazard_stall, 0);
        rst = 1'b0;

        // SUB x3, x1, x2
        set_id(OPC_R, 1'b1, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 32'd100, 32'd30, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("sub_op", alu_op, 32'b10000);
        check("sub_a", alu_a, 32'd100);
        check("sub_b", alu_b, 32'd30);
        check("sub_valid", ex_valid, 1);
        check("sub_rd", ex_rd, 3);
        check("sub_regwrite", ex_regwrite, 1);

        // ADDI x7, x6, -1 with funct7 bits set by the immediate
        set_id(OPC_I, 1'b1, 1'b1, 3'b000, 5'd6, 5'd31, 5'd7, 32'd5, 32'd77, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("addi_op", alu_op, 32'b00000);
        check("addi_b", alu_b, 32'hFFFF_FFFF);
        check("addi_a", alu_a, 32'd5);
        check("addi_store", ex_store_data, 32'd77);

        // MUL x10, x8, x9
        set_id(OPC_R, 1'b0, 1'b1, 3'b000, 5'd8, 5'd9, 5'd10, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("mul_op", alu_op, 32'b01000);
        check("mul_b", alu_b, 32'd7);

        // SLLI x12, x11, 4 (funct7 position bit set)
        set_id(OPC_I, 1'b1, 1'b0, 3'b001, 5'd11, 5'd4, 5'd12, 32'd1, 32'd0, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("slli_op", alu_op, 32'b00001);
        check("slli_b", alu_b, 32'd4);

        // Branch, no register write
        set_id(OPC_BR, 1'b0, 1'b0, 3'b001, 5'd14, 5'd15, 5'd16, 32'd1, 32'd2, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("br_op", alu_op, 32'b10000);
        check("br_regwrite", ex_regwrite, 0);
        check("br_valid", ex_valid, 1);

        // Forwarding priority on EX rs1=5 (data 0x33), rs2=6 (data 0x44)
        set_id(OPC_R, 1'b0, 1'b0, 3'b000, 5'd5, 5'd6, 5'd13, 32'h33, 32'h44, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        fwd_in(5'd5, 1'b1, 32'h11, 5'd5, 1'b1, 32'h22);
        #1;
        check("fwd_both_a", alu_a, FWD ? 32'h11 : 32'h33);
        check("fwd_both_hazard", hazard_stall, FWD ? 0 : 1);
        fwd_in(5'd0, 1'b1, 32'h11, 5'd5, 1'b1, 32'h22);
        #1;
        check("fwd_memwb_a", alu_a, FWD ? 32'h22 : 32'h33);
        fwd_in(5'd0, 1'b1, 32'h11, 5'd0, 1'b1, 32'h22);
        #1;
        check("fwd_x0_a", alu_a, 32'h33);
        fwd_in(5'd6, 1'b1, 32'h55, 5'd0, 1'b0, 32'h0);
        #1;
        check("fwd_rs2_store", ex_store_data, FWD ? 32'h55 : 32'h44);
        check("fwd_rs2_b", alu_b, FWD ? 32'h55 : 32'h44);
        fwd_in(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Capture-time bypass from MEM/WB
        @(negedge clk);
        set_id(OPC_R, 1'b0, 1'b0, 3'b000, 5'd14, 5'd2, 5'd17, 32'h55, 32'h9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        fwd_in(5'd0, 1'b0, 32'h0, 5'd14, 1'b1, 32'h66);
        tick();
        fwd_in(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        check("bypass_a", alu_a, 32'h66);
        check("bypass_b", alu_b, 32'h9);

        // lw x3, 4(x1), then dependent add; reset during the stall
        @(negedge clk);
        set_id(OPC_LS, 1'b0, 1'b0, 3'b010, 5'd1, 5'd20, 5'd3, 32'h100, 32'd0, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("lw_memread", ex_memread, 1);
        check("lw_b", alu_b, 32'd4);
        set_id(OPC_R, 1'b0, 1'b0, 3'b000, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_hazard", hazard_stall, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", ex_valid, 0);
        check("rst_mid_hazard", hazard_stall, 0);

        // Flush while load-use stall is active
        set_id(OPC_LS, 1'b0, 1'b0, 3'b010, 5'd1, 5'd20, 5'd3, 32'h100, 32'd0, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(OPC_R, 1'b0, 1'b0, 3'b000, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("flush_lu_hazard", hazard_stall, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_lu_valid", ex_valid, 0);
        check("flush_memread_gated", ex_memread, 0);
        check("flush_lu_hazard_after", hazard_stall, 0);

`ifdef ID_EX_FORWARD_EN
        // Load-use: one bubble, then load data via MEM/WB
        set_id(OPC_LS, 1'b0, 1'b0, 3'b010, 5'd1, 5'd20, 5'd3, 32'h100, 32'd0, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(OPC_R, 1'b0, 1'b0, 3'b000, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_stall_1", hazard_stall, 1);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_stall_done", hazard_stall, 0);
        fwd_in(5'd3, 1'b1, 32'h104, 5'd0, 1'b0, 32'h0);
        tick();
        fwd_in(5'd0, 1'b0, 32'h0, 5'd3, 1'b1, 32'hDEAD);
        #1;
        check("lu_valid", ex_valid, 1);
        check("lu_a", alu_a, 32'hDEAD);
        check("lu_b", alu_b, 32'hDEAD);
`else
        // addi x1,x0,7 ; add x2,x1,x1 : two stall cycles
        set_id(OPC_I, 1'b0, 1'b0, 3'b000, 5'd0, 5'd7, 5'd1, 32'd0, 32'd0, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(OPC_R, 1'b0, 1'b0, 3'b000, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("raw_stall_ex", hazard_stall, 1);
        tick();
        check("raw_bubble_1", ex_valid, 0);
        fwd_in(5'd1, 1'b1, 32'd7, 5'd0, 1'b0, 32'h0);
        #1;
        check("raw_stall_exmem", hazard_stall, 1);
        tick();
        check("raw_bubble_2", ex_valid, 0);
        fwd_in(5'd0, 1'b0, 32'h0, 5'd1, 1'b1, 32'd7);
        #1;
        check("raw_stall_done", hazard_stall, 0);
        tick();
        fwd_in(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        check("raw_valid", ex_valid, 1);
        check("raw_a", alu_a, 32'd7);
        check("raw_b", alu_b, 32'd7);
        check("raw_rd", ex_rd, 2);
`endif
        fwd_in(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // stall_in holds everything for 3 cycles
        @(negedge clk);
        set_id(OPC_R, 1'b0, 1'b0, 3'b111, 5'd21, 5'd22, 5'd20, 32'hA, 32'hB, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("and_op", alu_op, 32'b00111);
        check("and_a", alu_a, 32'hA);
        stall_in = 1'b1;
        set_id(OPC_R, 1'b0, 1'b0, 3'b110, 5'd23, 5'd24, 5'd25, 32'h1, 32'h2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", ex_valid, 1);
            check("hold_op", alu_op, 32'b00111);
            check("hold_a", alu_a, 32'hA);
            check("hold_b", alu_b, 32'hB);
            check("hold_rd", ex_rd, 20);
        end

        // flush beats stall_in
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall_in = 1'b0;
        check("flush_stall_valid", ex_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage RV32 core. It captures decoded operands and control from decode and resolves data hazards by forwarding from EX/MEM and MEM/WB, or by stalling on load-use. It drives the ALU's `A`, `B` and 5-bit `opcode` inputs, and passes memory and writeback control on to the EX/MEM register. Stall and flush handling also live here: a bubble is inserted on load-use, and the stage is squashed on a taken branch.

## Interface
- `XLEN`, 32, datapath width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `id_valid` input 1: decode holds a valid instruction.
- `id_rs1`, `id_rs2`, `id_rd` input 5 each: register indices.
- `id_rs1_data`, `id_rs2_data` input XLEN: register-file read data.
- `id_imm` input XLEN: sign-extended immediate.
- `id_funct3` input 3; `id_funct7_5`, `id_funct7_0` input 1 each: funct7 bits 5 and 0.
- `id_op_class` input 2: 00 R-type, 01 I-arith, 10 load/store, 11 branch.
- `id_alu_src` input 1: 1 means B takes the immediate.
- `id_regwrite`, `id_memread`, `id_memwrite` input 1 each.
- `exmem_rd` input 5; `exmem_regwrite` input 1; `exmem_result` input XLEN.
- `memwb_rd` input 5; `memwb_regwrite` input 1; `memwb_result` input XLEN.
- `stall_in` input 1: downstream freeze.
- `flush` input 1: taken branch.
- `hazard_stall` output 1: hold PC and IF/ID, decode instruction not accepted.
- `alu_a`, `alu_b` output XLEN: to ALU `A`/`B`.
- `alu_op` output 5: to ALU `opcode`.
- `ex_valid`, `ex_regwrite`, `ex_memread`, `ex_memwrite` output 1 each.
- `ex_rd` output 5.
- `ex_store_data` output XLEN: forwarded rs2 value.

## Operation
- **Registered state:** valid, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_src, alu_op, regwrite, memread, memwrite.
- **alu_op encoding:** `{funct7[5], funct7[0], funct3}`.
  - R-type: `{id_funct7_5, id_funct7_0, id_funct3}`. ADD 00000, SUB 10000, MUL 01000, AND 00111, OR 00110.
  - I-arith: `{2'b00, id_funct3}`. Immediate bits in the funct7 position are ignored, so ADDI never becomes SUB. SLLI gives 00001.
  - Load/store: 00000.
  - Branch: 10000.
- **Capture-time bypass:** if `memwb_regwrite` and `memwb_rd != 0` and `memwb_rd == id_rsN`, capture `memwb_result` instead of `id_rsN_data`. This covers the WB/ID same-cycle write.
- **Forwarding (combinational on registered rsN):**
  - EX/MEM match (regwrite, rd ≠ 0, rd == rsN) has priority over a MEM/WB match; otherwise the registered data is used.
  - x0 is never forwarded.
- **Operand outputs:**
  - `alu_a` = fwd_rs1.
  - `alu_b` = alu_src ? imm : fwd_rs2.
  - `ex_store_data` = fwd_rs2.
- **Load-use hazard:** `hazard_stall` = ex_valid & ex_memread & ex_rd ≠ 0 & (ex_rd == id_rs1 | ex_rd == id_rs2) & id_valid.
- **Per-cycle update priority:**
  1. `rst`: clear.
  2. `flush`: valid←0, beats `stall_in`.
  3. `stall_in`: hold all state.
  4. `hazard_stall`: bubble, valid←0.
  5. Else: capture decode, valid←id_valid.
- **Gating:** `ex_regwrite`/`ex_memread`/`ex_memwrite` are gated by valid; a bubble never writes.

## Timing
- One cycle from decode to EX register. `alu_*` outputs are combinational from the register plus the forwarding inputs.
- Reset: all registers 0.
  - Outputs: `ex_valid`=0, `alu_op`=00000, `alu_a`=`alu_b`=0, `ex_rd`=0, control 0.
  - `hazard_stall` is 0 because valid is 0.
- A load-use pair costs exactly one bubble cycle. The next cycle the load is in EX/MEM and its data reaches EX via MEM/WB forwarding.
- Flush during a load-use stall: the bubble is inserted regardless, and `hazard_stall` still reflects the current EX contents.
- Reset asserted mid-stall clears state. Decode re-presents its instruction after reset.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding as described; stall only on load-use.
- Not defined: no EX/MEM or MEM/WB forwarding muxes (`alu_a`/`alu_b` use registered data).
  - `hazard_stall` asserts on any RAW against the EX stage (`ex_rd`, `ex_regwrite`) or against `exmem_rd`/`exmem_regwrite`, with rd ≠ 0.
  - Capture-time bypass stays.

## Structure
- **Shared package `riscv_pkg`:**
  - op-class constants;
  - ALU opcode constants ALU_ADD/SUB/MUL/AND/OR/SLL (00000/10000/01000/00111/00110/00001);
  - forwarding-select enum FWD_REG/FWD_EXMEM/FWD_MEMWB.
- **One sub-module, `ex_forward_unit`:** combinational select per operand, instantiated inside `id_ex_stage`.

## Test plan
- **Reset:** `rst` high with `id_valid`=1 → next cycle `ex_valid`=0, `alu_op`=00000, `alu_a`=`alu_b`=0.
- **Opcode mapping:**
  - `SUB` (funct7_5=1, funct3=000) → `alu_op`=10000.
  - `ADDI` imm=-1 (funct7 bits set) → `alu_op`=00000, `alu_b`=0xFFFFFFFF.
  - `MUL` → 01000.
- **Forward priority:** EX/MEM rd=5 result 0x11 and MEM/WB rd=5 result 0x22, EX rs1=5 → `alu_a`=0x11. With rd=0 on both → registered data.
- **Load-use:** `lw x3` in EX, decode `add x4,x3,x3` → `hazard_stall`=1 for one cycle, bubble (`ex_valid`=0), then `alu_a`=`alu_b`=load data via MEM/WB.
- **Flush vs stall:** `flush`=1 and `stall_in`=1 together → `ex_valid`=0 next cycle. `stall_in` alone → all outputs unchanged over 3 cycles.
- **Without `ID_EX_FORWARD_EN`:** back-to-back `addi x1,x0,7`; `add x2,x1,x1` → two stall cycles, then `alu_a`=`alu_b`=7.
